// File: rtl/retire_ctrl.sv
// In-order retirement controller: picks the retiring prefix of the ROB head, frees old mappings, handles flush/halt.
// Optional statistics counters are compiled in with the RETIRE_STATS_EN macro.
module retire_ctrl #(
  parameter int N           = 3,
  parameter int PHYS_REG_SZ = 64,
  parameter int PR_W        = $clog2(PHYS_REG_SZ),
  parameter int CNT_W       = $clog2(N + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N-1:0]             head_valid,
  input  logic [N-1:0][PR_W-1:0]   head_T_new,
  input  logic [N-1:0][PR_W-1:0]   head_T_old,
  input  logic [N-1:0]             head_has_dest,
  input  logic [N-1:0]             head_done,
  input  logic [N-1:0]             head_is_store,
  input  logic [N-1:0]             head_is_halt,
  input  logic [N-1:0]             head_mispredict,
  input  logic [PHYS_REG_SZ-1:0]   complete_list,
  input  logic                     store_ready,
  output logic [CNT_W-1:0]         num_retiring,
  output logic                     store_commit,
  output logic [N-1:0]             free_valid,
  output logic [N-1:0][PR_W-1:0]   free_regs,
  output logic                     flush,
  output logic                     halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [63:0]              retired_count,
  output logic [31:0]              stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     flush_q;
  logic                     halted_q;
  logic [N-1:0]             free_valid_q;
  logic [N-1:0][PR_W-1:0]   free_regs_q;

  logic [N-1:0]             ready_s;
  logic [N-1:0]             retire_s;
  logic [N-1:0]             free_valid_d;
  logic [N-1:0][PR_W-1:0]   free_regs_d;
  logic [CNT_W-1:0]         num_s;
  logic                     store_commit_s;
  logic                     halt_ret_s;
  logic                     mis_ret_s;
  logic                     stop_s;
  logic                     store_seen_s;
  logic                     run_s;

  // Per-slot readiness; invalid slots never look at their other fields.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < N; i++) begin
      if (head_valid[i]) begin
        if (head_has_dest[i]) begin
          ready_s[i] = complete_list[head_T_new[i]];
        end else begin
          ready_s[i] = head_done[i];
        end
      end else begin
        ready_s[i] = 1'b0;
      end
    end
  end

  // Walk slots oldest first; the prefix ends at a non-ready slot, a held store, or after a halt/mispredict.
  always_comb begin
    run_s          = (state_q == ST_RUN) && reset_n;
    retire_s       = '0;
    num_s          = '0;
    store_commit_s = 1'b0;
    halt_ret_s     = 1'b0;
    mis_ret_s      = 1'b0;
    stop_s         = !run_s;
    store_seen_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!stop_s) begin
        if (!ready_s[i]) begin
          stop_s = 1'b1;
        end else if (head_is_store[i] && store_seen_s) begin
          stop_s = 1'b1;
        end else if (head_is_store[i] && !store_ready) begin
          store_seen_s   = 1'b1;
          store_commit_s = 1'b1;
          stop_s         = 1'b1;
        end else begin
          if (head_is_store[i]) begin
            store_seen_s   = 1'b1;
            store_commit_s = 1'b1;
          end else begin
            store_seen_s = store_seen_s;
          end
          retire_s[i] = 1'b1;
          num_s       = num_s + CNT_W'(1);
          if (head_is_halt[i] || head_mispredict[i]) begin
            halt_ret_s = head_is_halt[i];
            mis_ret_s  = head_mispredict[i];
            stop_s     = 1'b1;
          end else begin
            stop_s = 1'b0;
          end
        end
      end else begin
        stop_s = 1'b1;
      end
    end
  end

  // Next free-list entries: only retired slots that own a destination.
  always_comb begin
    free_valid_d = retire_s & head_has_dest;
    free_regs_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (free_valid_d[i]) begin
        free_regs_d[i] = head_T_old[i];
      end else begin
        free_regs_d[i] = '0;
      end
    end
  end

  // Control FSM with registered flush/halted/free outputs; halt wins over mispredict.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      flush_q      <= 1'b0;
      halted_q     <= 1'b0;
      free_valid_q <= '0;
      free_regs_q  <= '0;
    end else begin
      free_valid_q <= free_valid_d;
      free_regs_q  <= free_regs_d;
      case (state_q)
        ST_RUN: begin
          if (halt_ret_s) begin
            state_q  <= ST_HALTED;
            flush_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (mis_ret_s) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 1'b1;
            halted_q <= 1'b0;
          end else begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state_q  <= ST_RUN;
          flush_q  <= 1'b0;
          halted_q <= 1'b0;
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          flush_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          flush_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign num_retiring = num_s;
  assign store_commit = store_commit_s;
  assign free_valid   = free_valid_q;
  assign free_regs    = free_regs_q;
  assign flush        = flush_q;
  assign halted       = halted_q;

`ifdef RETIRE_STATS_EN
  logic [63:0] retired_count_q;
  logic [31:0] stall_cycles_q;
  logic [63:0] num_ext_s;

  assign num_ext_s = {{(64-CNT_W){1'b0}}, num_s};

  // Saturating retirement and head-stall counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_count_q <= 64'd0;
      stall_cycles_q  <= 32'd0;
    end else begin
      if (retired_count_q > (64'hFFFF_FFFF_FFFF_FFFF - num_ext_s)) begin
        retired_count_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        retired_count_q <= retired_count_q + num_ext_s;
      end
      if ((state_q == ST_RUN) && head_valid[0] && (num_s == '0) &&
          (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
    end
  end

  assign retired_count = retired_count_q;
  assign stall_cycles  = stall_cycles_q;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed and randomized bench for retire_ctrl against a rule-level reference model.
module tb_retire_ctrl;
  localparam int N    = 3;
  localparam int PRS  = 64;
  localparam int PR_W = 6;
  localparam int CW   = 2;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [N-1:0]           head_valid, head_has_dest, head_done, head_is_store, head_is_halt, head_mispredict;
  logic [N-1:0][PR_W-1:0] head_T_new, head_T_old;
  logic [PRS-1:0]         complete_list;
  logic                   store_ready;
  logic [CW-1:0]          num_retiring;
  logic                   store_commit;
  logic [N-1:0]           free_valid;
  logic [N-1:0][PR_W-1:0] free_regs;
  logic                   flush, halted;

  int tests = 0;
  int fails = 0;
  int mode  = 0;            // 0 = running, 1 = flushing, 2 = halted
  logic [N-1:0]           exp_fv = '0;
  logic [N-1:0][PR_W-1:0] exp_fr = '0;
  int exp_num;
  bit exp_sc;
  int last_num;
  int halted_cycles = 0;

  retire_ctrl #(.N(N), .PHYS_REG_SZ(PRS)) dut (
    .clock(clock), .reset_n(reset_n),
    .head_valid(head_valid), .head_T_new(head_T_new), .head_T_old(head_T_old),
    .head_has_dest(head_has_dest), .head_done(head_done), .head_is_store(head_is_store),
    .head_is_halt(head_is_halt), .head_mispredict(head_mispredict),
    .complete_list(complete_list), .store_ready(store_ready),
    .num_retiring(num_retiring), .store_commit(store_commit),
    .free_valid(free_valid), .free_regs(free_regs), .flush(flush), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit slot_ready(input int i);
    if (!head_valid[i]) return 1'b0;
    return head_has_dest[i] ? complete_list[head_T_new[i]] : head_done[i];
  endfunction

  // Prefix length = min of the limits each rule imposes.
  task automatic model_comb();
    int nr = N, term = N, s1 = -1, s2 = N, l0;
    bit term_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!slot_ready(i) && nr == N) nr = i;
      if (head_valid[i] && (head_is_halt[i] || head_mispredict[i]) && !term_found) begin
        term = i + 1;
        term_found = 1'b1;
      end
      if (head_valid[i] && head_is_store[i]) begin
        if (s1 < 0) s1 = i;
        else if (s2 == N) s2 = i;
      end
    end
    l0 = (nr < term) ? nr : term;
    exp_sc  = (s1 >= 0) && (s1 < l0);
    exp_num = l0;
    if (s2 < exp_num) exp_num = s2;
    if (s1 >= 0 && !store_ready && s1 < exp_num) exp_num = s1;
    if (mode != 0 || !reset_n) begin
      exp_num = 0;
      exp_sc  = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already applied; checks, advances model, steps one clock.
  task automatic cycle(input string tag);
    int lastslot;
    #1;
    model_comb();
    chk({tag, ".num"}, 64'(num_retiring), 64'(exp_num));
    chk({tag, ".sc"}, 64'(store_commit), 64'(exp_sc));
    chk({tag, ".fv"}, 64'(free_valid), 64'(exp_fv));
    chk({tag, ".flush"}, 64'(flush), 64'(mode == 1));
    chk({tag, ".halted"}, 64'(halted), 64'(mode == 2));
    for (int i = 0; i < N; i++)
      if (exp_fv[i]) chk({tag, ".fr"}, 64'(free_regs[i]), 64'(exp_fr[i]));
    last_num = int'(num_retiring);
    for (int i = 0; i < N; i++) begin
      exp_fv[i] = (i < exp_num) && head_has_dest[i];
      exp_fr[i] = head_T_old[i];
    end
    if (mode == 1) mode = 0;
    else if (mode == 0 && exp_num > 0) begin
      lastslot = exp_num - 1;
      if (head_is_halt[lastslot]) mode = 2;
      else if (head_mispredict[lastslot]) mode = 1;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, ".rst_fv"}, 64'(free_valid), 64'd0);
    chk({tag, ".rst_fr"}, 64'(free_regs), 64'd0);
    chk({tag, ".rst_flush"}, 64'(flush), 64'd0);
    chk({tag, ".rst_halted"}, 64'(halted), 64'd0);
    chk({tag, ".rst_num"}, 64'(num_retiring), 64'd0);
    chk({tag, ".rst_sc"}, 64'(store_commit), 64'd0);
    mode = 0;
    exp_fv = '0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic all_ready();
    head_valid      = 3'b111;
    head_has_dest   = 3'b111;
    head_done       = 3'b111;
    head_is_store   = 3'b000;
    head_is_halt    = 3'b000;
    head_mispredict = 3'b000;
    complete_list   = {PRS{1'b1}};
    store_ready     = 1'b1;
    for (int i = 0; i < N; i++) begin
      head_T_new[i] = PR_W'($urandom_range(0, PRS - 1));
      head_T_old[i] = PR_W'($urandom_range(0, PRS - 1));
    end
  endtask

  task automatic randomize_inputs();
    head_valid      = N'($urandom | $urandom);
    head_has_dest   = N'($urandom);
    head_done       = N'($urandom | $urandom);
    head_is_store   = N'($urandom & $urandom);
    head_is_halt    = 3'b000;
    head_mispredict = 3'b000;
    for (int i = 0; i < N; i++) begin
      head_T_new[i] = PR_W'($urandom_range(0, PRS - 1));
      head_T_old[i] = PR_W'($urandom_range(0, PRS - 1));
      if ($urandom_range(0, 99) < 3) head_is_halt[i] = 1'b1;
      if ($urandom_range(0, 99) < 8) head_mispredict[i] = 1'b1;
    end
    complete_list = {$urandom | $urandom, $urandom | $urandom};
    store_ready   = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    reset_n = 1'b0;
    all_ready();
    @(negedge clock);
    do_reset("init");

    // Full-width retire with recognizable old mappings.
    all_ready();
    head_T_old = {6'd42, 6'd17, 6'd5};
    cycle("full");
    chk("full.count", 64'(last_num), 64'd3);
    chk("full.fv_next", 64'(free_valid), 64'd7);
    chk("full.fr_next", 64'(free_regs), 64'({6'd42, 6'd17, 6'd5}));

    // Middle slot waiting on its destination.
    all_ready();
    head_T_new = {6'd3, 6'd9, 6'd1};
    complete_list[9] = 1'b0;
    cycle("notready");
    chk("notready.count", 64'(last_num), 64'd1);
    chk("notready.fv_next", 64'(free_valid), 64'd1);

    // Two stores: second one is held; no store acceptance holds the first.
    all_ready();
    head_is_store = 3'b101;
    cycle("store_ok");
    chk("store_ok.count", 64'(last_num), 64'd2);
    all_ready();
    head_is_store = 3'b101;
    store_ready = 1'b0;
    cycle("store_wait");
    chk("store_wait.count", 64'(last_num), 64'd0);

    // Mispredict in slot 1, flush cycle, then resume.
    all_ready();
    head_mispredict = 3'b010;
    cycle("mis");
    chk("mis.count", 64'(last_num), 64'd2);
    all_ready();
    cycle("flush");
    chk("flush.count", 64'(last_num), 64'd0);
    cycle("resume");
    chk("resume.count", 64'(last_num), 64'd3);

    // Reset taken in the middle of a flush.
    all_ready();
    head_mispredict = 3'b001;
    cycle("mis2");
    do_reset("midflush");
    all_ready();
    cycle("postflush");

    // Halt + mispredict on the same slot: halt wins; absorbing until reset.
    all_ready();
    head_is_halt = 3'b001;
    head_mispredict = 3'b001;
    cycle("halt");
    chk("halt.count", 64'(last_num), 64'd1);
    all_ready();
    for (int k = 0; k < 20; k++) cycle("halted");
    do_reset("halt");
    all_ready();
    cycle("after_halt");
    chk("after_halt.count", 64'(last_num), 64'd3);

    // Invalid slots carrying unknown attributes must not matter.
    all_ready();
    head_valid = 3'b011;
    head_is_halt[2] = 1'bx;
    head_is_store[2] = 1'bx;
    head_T_new[2] = 'x;
    cycle("invalid_x");
    chk("invalid_x.count", 64'(last_num), 64'd2);

    for (int k = 0; k < 500; k++) begin
      randomize_inputs();
      if (mode == 2) halted_cycles++;
      if (halted_cycles > 3) begin
        halted_cycles = 0;
        do_reset("rand");
      end else begin
        cycle("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
